// File: rtl/pc_adder_core.sv
// pc_adder_core: next-sequential-PC generator for the fetch stage.
// Produces addr + STEP combinationally, together with wrap and misaligned
// status flags. It also provides a registered copy of the sum and wrap flag,
// with a valid flag.
// Optional feature: define PC_ADDER_MISALIGN_CHECK_EN to drive `misaligned`
// from addr[1:0]. When it is undefined, `misaligned` is tied to 0.
module pc_adder_core #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned STEP = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] addr,
   input  logic            en,
   output logic [XLEN-1:0] pc_plus_4,
   output logic            wrap,
   output logic            misaligned,
   output logic [XLEN-1:0] pc_plus_4_q,
   output logic            wrap_q,
   output logic            valid_q
);

   localparam logic [XLEN-1:0] STEP_W = XLEN'(STEP);

   logic [XLEN:0]   sum;
   logic [XLEN-1:0] pc_plus_4_d;
   logic            wrap_d;
   logic            valid_d;

   // Widened add: the extra top bit is the carry-out, and it is exposed only as wrap
   always_comb begin
      sum       = {1'b0, addr} + {1'b0, STEP_W};
      pc_plus_4 = sum[XLEN-1:0];
      wrap      = sum[XLEN];
   end

   // Advisory alignment flag; it never alters the increment
   always_comb begin
`ifdef PC_ADDER_MISALIGN_CHECK_EN
      misaligned = |addr[1:0];
`else
      misaligned = 1'b0;
`endif
   end

   // Next state for the registered stage: load when enabled, otherwise hold
   always_comb begin
      pc_plus_4_d = pc_plus_4_q;
      wrap_d      = wrap_q;
      valid_d     = valid_q;
      if (en) begin
         pc_plus_4_d = pc_plus_4;
         wrap_d      = wrap;
         valid_d     = 1'b1;
      end
   end

   // Registered stage; reset takes priority over enable and loads constants only
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_plus_4_q <= '0;
         wrap_q      <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         pc_plus_4_q <= pc_plus_4_d;
         wrap_q      <= wrap_d;
         valid_q     <= valid_d;
      end
   end

endmodule

// File: tb/tb_pc_adder_core.sv
// Scoreboard bench for pc_adder_core. The driver pushes expected values from
// an arithmetic reference model into a queue. The monitor pops one entry on
// each falling edge and compares it against the DUT outputs.
module tb_pc_adder_core;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr;
   logic        en;
   logic [31:0] pc_plus_4, pc_plus_4_q;
   logic        wrap, misaligned, wrap_q, valid_q;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] pc;
      logic        wr;
      logic        mis;
      logic [31:0] pc_q;
      logic        wr_q;
      logic        vld_q;
   } exp_t;

   exp_t sb[$];

   // Reference model state for the registered outputs
   logic [31:0] m_pc;
   logic        m_wrap, m_vld;
   logic        p_rst, p_en;
   logic [31:0] p_addr;

   pc_adder_core #(.XLEN(32), .STEP(4)) dut (
      .clk(clk), .rst(rst), .addr(addr), .en(en),
      .pc_plus_4(pc_plus_4), .wrap(wrap), .misaligned(misaligned),
      .pc_plus_4_q(pc_plus_4_q), .wrap_q(wrap_q), .valid_q(valid_q)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_sum(input logic [31:0] a);
      longint unsigned s;
      s = longint'(a) + 64'd4;
      return s[31:0];
   endfunction

   function automatic logic ref_wrap(input logic [31:0] a);
      return (longint'(a) + 64'd4) >= 64'h1_0000_0000;
   endfunction

   function automatic logic ref_mis(input logic [31:0] a);
`ifdef PC_ADDER_MISALIGN_CHECK_EN
      return (a % 4) != 0;
`else
      return 1'b0;
`endif
   endfunction

   // One cycle: fold the previous inputs into the model, apply new inputs, push expectation
   task automatic step(input logic r, input logic e, input logic [31:0] a);
      exp_t x;
      @(posedge clk);
      #1;
      if (p_rst) begin
         m_pc = 32'h0; m_wrap = 1'b0; m_vld = 1'b0;
      end else if (p_en) begin
         m_pc = ref_sum(p_addr); m_wrap = ref_wrap(p_addr); m_vld = 1'b1;
      end
      rst = r; en = e; addr = a;
      p_rst = r; p_en = e; p_addr = a;
      x.a = a; x.pc = ref_sum(a); x.wr = ref_wrap(a); x.mis = ref_mis(a);
      x.pc_q = m_pc; x.wr_q = m_wrap; x.vld_q = m_vld;
      sb.push_back(x);
   endtask

   // Monitor: compare the DUT against the oldest expectation, away from the active edge
   always @(negedge clk) begin
      exp_t x;
      if (sb.size() > 0) begin
         x = sb.pop_front();
         n_vec++;
         if (pc_plus_4 !== x.pc) begin
            n_err++; $display("FAIL pc_plus_4 addr=%h got=%h exp=%h", x.a, pc_plus_4, x.pc);
         end
         if (wrap !== x.wr) begin
            n_err++; $display("FAIL wrap addr=%h got=%b exp=%b", x.a, wrap, x.wr);
         end
         if (misaligned !== x.mis) begin
            n_err++; $display("FAIL misaligned addr=%h got=%b exp=%b", x.a, misaligned, x.mis);
         end
         if (pc_plus_4_q !== x.pc_q) begin
            n_err++; $display("FAIL pc_plus_4_q got=%h exp=%h", pc_plus_4_q, x.pc_q);
         end
         if (wrap_q !== x.wr_q) begin
            n_err++; $display("FAIL wrap_q got=%b exp=%b", wrap_q, x.wr_q);
         end
         if (valid_q !== x.vld_q) begin
            n_err++; $display("FAIL valid_q got=%b exp=%b", valid_q, x.vld_q);
         end
      end
   end

   initial begin
      logic [31:0] ra;
      rst = 1'b1; en = 1'b1; addr = 32'h0;
      p_rst = 1'b1; p_en = 1'b1; p_addr = 32'h0;
      m_pc = 32'h0; m_wrap = 1'b0; m_vld = 1'b0;
      // Reset, with en high to show reset priority
      step(1'b1, 1'b1, 32'h1234_5678);
      step(1'b1, 1'b0, 32'hFFFF_FFFC);
      // Sequential sweep
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h4);
      step(1'b0, 1'b0, 32'h8);
      step(1'b0, 1'b0, 32'hC);
      step(1'b0, 1'b0, 32'h10);
      // Wrap boundaries and a misaligned address
      step(1'b0, 1'b0, 32'hFFFF_FFFC);
      step(1'b0, 1'b0, 32'hFFFF_FFF8);
      step(1'b0, 1'b0, 32'hFFFF_FFFB);
      step(1'b0, 1'b0, 32'h0000_0002);
      // Register and enable, then hold
      step(1'b0, 1'b1, 32'h100);
      step(1'b0, 1'b0, 32'h200);
      step(1'b0, 1'b0, 32'h300);
      // Registered wrap
      step(1'b0, 1'b1, 32'hFFFF_FFFD);
      step(1'b0, 1'b0, 32'h100);
      step(1'b0, 1'b1, 32'h100);
      // Reset mid-operation with en high
      step(1'b1, 1'b1, 32'h0000_0500);
      step(1'b0, 1'b0, 32'h0000_0600);
      step(1'b0, 1'b1, 32'h0000_0700);
      // Random traffic, biased toward the wrap region
      for (int i = 0; i < 300; i++) begin
         ra = $urandom;
         if ($urandom_range(0, 3) == 0) ra = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         step($urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1, ra);
      end
      // Drain the scoreboard, bounded in cycles
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() > 0) begin
         n_err++;
         $display("FAIL drain left=%0d exp=0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
